// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//
// Multi-cycle WIDTH-bit adder/subtractor built around one 2-bit adder slice.
// Operands are latched in IDLE. RUN then processes one 2-bit digit per cycle,
// least-significant digit first, and chains the carry between digits. The
// finished result is held in DONE until the consumer accepts it.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operand request valid
//   in_ready   block can accept operands (state == IDLE)
//   a, b       WIDTH-bit operands
//   sub        0 = a + b, 1 = a - b
//   out_valid  result valid (state == DONE)
//   out_ready  consumer accepts result
//   result     sum or difference, modulo 2^WIDTH
//   carry_out  final carry; on subtract, 1 = no borrow (a >= b unsigned)
//   overflow   signed two's-complement overflow
// -----------------------------------------------------------------------------
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int DIGITS = WIDTH / 2;
  localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(DIGITS - 1);

  generate
    if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
      $error("serial_adder_ctrl: WIDTH must be even and >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   cnt;
  logic            carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;   // already inverted for subtract

  // Digit slice: pick digit cnt of each operand and add with the chained carry.
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [1:0]       sum_dig;
  logic             carry_dig;

  assign a_sh = a_q >> {cnt, 1'b0};
  assign b_sh = b_q >> {cnt, 1'b0};
  assign {carry_dig, sum_dig} = 3'(a_sh[1:0]) + 3'(b_sh[1:0]) + 3'(carry_q);

  // Handshake flags decode registered state only, so neither has a
  // combinational path from any input.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // NOTE: sequential state is always written with <= so every flop samples
  // the pre-edge value of its sources, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: the default assignment first means every path assigns state_next,
  // so no latch can be inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid)               state_next = RUN;
      RUN:     if (cnt == LAST_DIGIT)      state_next = DONE;
      DONE:    if (out_ready)              state_next = IDLE;
      default:                             state_next = IDLE;
    endcase
  end

  // NOTE: operand copies carry no reset. They are always loaded before being
  // read, so a reset would only add fan-out on rst.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      a_q <= a;
      b_q <= sub ? ~b : b;
    end
  end

  // Digit counter, carry chain and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      carry_q   <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtract is a + ~b + 1: the +1 enters as the initial carry.
            carry_q <= sub;
            cnt     <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (cnt == CW'(i)) result[2*i +: 2] <= sum_dig;
          end
          carry_q <= carry_dig;
          if (cnt == LAST_DIGIT) begin
            carry_out <= carry_dig;
            // Overflow: operand signs agree but the result sign differs.
            overflow  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                         (sum_dig[1] != a_q[WIDTH-1]);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;  // DONE holds every output stable under backpressure
      endcase
    end
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Multi-cycle sequencer that computes a WIDTH-bit add or subtract using a single 2-bit adder slice with carry chaining. Each cycle it processes one 2-bit digit, least-significant digit first. Operands and results use valid/ready handshakes. It is the area-minimal alternative to a full-width adder for non-critical ALU paths in the processor.

Parameters:
WIDTH, 8, operand and result width in bits; must be even and >= 2 (elaboration error otherwise)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand request valid
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
sub  input  1  0 = A+B, 1 = A-B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  sum or difference, modulo 2^WIDTH
carry_out  output  1  final carry; for subtract, 1 = no borrow (A >= B unsigned)
overflow  output  1  signed two's-complement overflow

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- States: IDLE, RUN, DONE.
- Reset: state=IDLE, in_ready=1, out_valid=0, result=0, carry_out=0, overflow=0, digit counter=0, internal carry=0. Reset during RUN or DONE abandons the operation; no result is emitted.
- in_ready = (state==IDLE). out_valid = (state==DONE). Both are registered-state decodes with no combinational path from any input.
- IDLE: when in_valid=1, latch a, (sub ? ~b : b), and sub. Set carry = sub, counter = 0, then go to RUN. When in_valid=0, stay.
- RUN, each cycle: digit i = counter. Compute {c, s[1:0]} = A[2i+1:2i] + B'[2i+1:2i] + carry. Write s into result[2i+1:2i] and store c as carry. When i==WIDTH/2-1, also latch carry_out=c and overflow=(A[W-1]==B'[W-1]) && (s[1]!=A[W-1]), then go to DONE. Otherwise counter+1.
- Latency: operands accepted at edge E. out_valid is high after edge E+WIDTH/2 (WIDTH/2 RUN cycles). For WIDTH=8, 4 RUN cycles.
- DONE: result, carry_out and overflow are held stable while out_valid=1 and out_ready=0 (unlimited backpressure). When out_ready=1, go to IDLE next edge. No same-cycle accept of new operands: minimum initiation interval is WIDTH/2+2 cycles.
- Inputs a, b and sub may change freely after acceptance; only the latched copies are used.
- in_valid outside IDLE is ignored; the requester holds it until in_ready.
- result bits not yet computed during RUN are don't-care. They are only defined while out_valid=1.
- Counter width is clog2(WIDTH/2), minimum 1 bit. It never wraps, because the exit is on the terminal count.

Test Plan:
- WIDTH=8, a=0x0F, b=0x01, sub=0 -> after 4 RUN cycles: out_valid=1, result=0x10, carry_out=0, overflow=0.
- a=0xFF, b=0x01, sub=0 -> result=0x00, carry_out=1, overflow=0. Then a=0x7F, b=0x01 -> result=0x80, carry_out=0, overflow=1.
- Subtract: a=0x05, b=0x07, sub=1 -> result=0xFE, carry_out=0, overflow=0. Then a=0x80, b=0x01, sub=1 -> result=0x7F, carry_out=1, overflow=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> outputs stable and in_ready=0 throughout. Pulse out_ready=1 -> IDLE with in_ready=1 on the next cycle. Also change a and b mid-RUN -> result unaffected.
- Reset mid-RUN: assert rst after 2 digits -> next cycle state=IDLE, in_ready=1, out_valid=0, all outputs 0. A following op 0x12+0x34 -> 0x46 with correct latency.
- Back-to-back with in_valid held high: second operand set accepted exactly on the cycle after the out_valid/out_ready handshake. Random sweep of 1000 ops for WIDTH=8 and WIDTH=32 against a reference model for result, carry_out and overflow.
